cond_flag_bank: RTL and testbench



---
 rtl/cond_flag_bank.sv | 112 +++++++++++
 tb/tb_cond_flag_bank.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_flag_bank.sv
// Multi-channel condition capture: per-channel synchroniser, edge detect,
// mode-selectable flag and saturating rise counter.
module cond_flag_bank #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [CHANNELS-1:0]           cond_in,
  input  logic [2*CHANNELS-1:0]         mode,
  input  logic [CHANNELS-1:0]           clear,
  output logic [CHANNELS-1:0]           flag_o,
  output logic [CHANNELS-1:0]           rise_o,
  output logic [CHANNELS-1:0]           fall_o,
  output logic [CHANNELS*CNT_WIDTH-1:0] count_o,
  output logic                          any_flag_o
);

  typedef enum logic [1:0] {
    FOLLOW = 2'b00,
    STICKY = 2'b01,
    TOGGLE = 2'b10,
    PULSE  = 2'b11
  } mode_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
  logic [CNT_WIDTH-1:0]   cnt_q  [CHANNELS];
  logic [CNT_WIDTH-1:0]   cnt_d  [CHANNELS];

  logic [CHANNELS-1:0] cond_s;
  logic [CHANNELS-1:0] prev_q;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] fall;
  logic [CHANNELS-1:0] flag_q;
  logic [CHANNELS-1:0] flag_d;
  logic [CHANNELS-1:0] rise_q;
  logic [CHANNELS-1:0] fall_q;
  logic                any_q;
  logic                any_d;

  always_comb begin
    cond_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cond_s[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  assign rise = cond_s & ~prev_q;
  assign fall = ~cond_s & prev_q;

  // Clear lands first, then the edge event is applied on top of it.
  always_comb begin
    flag_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = '0;
      unique case (mode_e'(mode[2*i +: 2]))
        FOLLOW: flag_d[i] = cond_s[i];
        STICKY: flag_d[i] = (flag_q[i] & ~clear[i]) | rise[i];
        TOGGLE: flag_d[i] = (flag_q[i] & ~clear[i]) ^ rise[i];
        PULSE:  flag_d[i] = rise[i];
      endcase
      cnt_d[i] = clear[i] ? '0 : cnt_q[i];
      if (rise[i] && (cnt_d[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_d[i] + CNT_WIDTH'(1);
      end
    end
    any_d = |flag_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      prev_q <= '0;
      flag_q <= '0;
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        sync_q[i][0] <= cond_in[i];
        for (int k = 1; k < SYNC_STAGES; k++) begin
          sync_q[i][k] <= sync_q[i][k-1];
        end
        cnt_q[i] <= cnt_d[i];
      end
      prev_q <= cond_s;
      flag_q <= flag_d;
      rise_q <= rise;
      fall_q <= fall;
      any_q  <= any_d;
    end
  end

  always_comb begin
    count_o = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      count_o[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
    end
  end

  assign flag_o     = flag_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign any_flag_o = any_q;

endmodule

// File: tb/tb_cond_flag_bank.sv
// Bench for cond_flag_bank: directed scenarios plus random traffic,
// all checked against a delay-line reference model.
module tb_cond_flag_bank;

  localparam int CH = 4;
  localparam int SS = 2;
  localparam int CW = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [CH-1:0]    cond_in = '0;
  logic [2*CH-1:0]  mode = '0;
  logic [CH-1:0]    clear = '0;
  logic [CH-1:0]    flag_o;
  logic [CH-1:0]    rise_o;
  logic [CH-1:0]    fall_o;
  logic [CH*CW-1:0] count_o;
  logic             any_flag_o;

  always #5 clk = ~clk;

  cond_flag_bank #(
    .CHANNELS(CH),
    .SYNC_STAGES(SS),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cond_in(cond_in),
    .mode(mode),
    .clear(clear),
    .flag_o(flag_o),
    .rise_o(rise_o),
    .fall_o(fall_o),
    .count_o(count_o),
    .any_flag_o(any_flag_o)
  );

  int total = 0;
  int bad = 0;

  logic [CH-1:0] hq [$];
  logic [CH-1:0] mflag;
  logic [CH-1:0] mrise;
  logic [CH-1:0] mfall;
  logic          many;
  int            mcnt [CH];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    hq.delete();
    repeat (SS + 1) hq.push_back('0);
    mflag = '0;
    mrise = '0;
    mfall = '0;
    many  = 1'b0;
    foreach (mcnt[i]) mcnt[i] = 0;
  endtask

  // cond_s seen at an edge is the input sampled SS edges earlier
  task automatic m_edge();
    logic [CH-1:0] h0, h1;
    logic c, p, r;
    int md;
    if (!rst_n) begin
      m_reset();
      return;
    end
    h0 = hq[0];
    h1 = hq[1];
    for (int i = 0; i < CH; i++) begin
      p = h0[i];
      c = h1[i];
      r = c & !p;
      mrise[i] = r;
      mfall[i] = !c & p;
      md = int'(mode[2*i +: 2]);
      case (md)
        0: mflag[i] = c;
        1: begin
          if (clear[i]) mflag[i] = 1'b0;
          if (r) mflag[i] = 1'b1;
        end
        2: begin
          if (clear[i]) mflag[i] = 1'b0;
          if (r) mflag[i] = !mflag[i];
        end
        default: mflag[i] = r;
      endcase
      if (clear[i]) mcnt[i] = 0;
      if (r && mcnt[i] < (1 << CW) - 1) mcnt[i]++;
    end
    many = |mflag;
    void'(hq.pop_front());
    hq.push_back(cond_in);
  endtask

  function automatic logic [63:0] mpack();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < CH; i++) v[i*CW +: CW] = CW'(mcnt[i]);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
    chk("flag", flag_o, mflag);
    chk("rise", rise_o, mrise);
    chk("fall", fall_o, mfall);
    chk("count", count_o, mpack());
    chk("any", any_flag_o, many);
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    steps(3);
    rst_n = 1'b1;
  endtask

  task automatic pulse(input logic [CH-1:0] m, input int hi, input int lo);
    cond_in = cond_in | m;
    steps(hi);
    cond_in = cond_in & ~m;
    steps(lo);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_flag"}, flag_o, 0);
    chk({tag, "_rise"}, rise_o, 0);
    chk({tag, "_fall"}, fall_o, 0);
    chk({tag, "_count"}, count_o, 0);
    chk({tag, "_any"}, any_flag_o, 0);
  endtask

  initial begin
    m_reset();
    cond_in = 4'hF;
    #1 rst_n = 1'b0;
    #2;
    chk_zero("rst_now");
    steps(3);
    rst_n = 1'b1;
    steps(2);
    chk("lat_early", rise_o, 0);
    step();
    chk("lat_rise", rise_o, 4'hF);
    chk("lat_count", count_o, 32'h01010101);
    chk("lat_flag", flag_o, 4'hF);
    steps(2);

    cond_in = '0;
    do_reset();
    mode = 8'hE4;
    repeat (2) pulse(4'hF, 4, 4);
    steps(4);
    chk("modes_count", count_o, 32'h02020202);
    chk("modes_sticky", flag_o[1], 1'b1);
    chk("modes_toggle", flag_o[2], 1'b0);

    mode = '0;
    do_reset();
    repeat (300) pulse(4'h1, 1, 1);
    steps(3);
    chk("sat_300", count_o[7:0], 8'd255);
    pulse(4'h1, 1, 3);
    chk("sat_301", count_o[7:0], 8'd255);

    do_reset();
    mode = 8'h04;
    repeat (5) pulse(4'h2, 1, 1);
    steps(3);
    chk("coll_pre", count_o[15:8], 8'd5);
    cond_in[1] = 1'b1;
    steps(2);
    clear = 4'h2;
    step();
    chk("coll_flag", flag_o[1], 1'b1);
    chk("coll_count", count_o[15:8], 8'd1);
    step();
    chk("clr_flag", flag_o[1], 1'b0);
    chk("clr_count", count_o[15:8], 8'd0);
    clear = '0;
    cond_in = '0;
    steps(3);

    do_reset();
    mode = 8'h01;
    repeat (6) pulse(4'h1, 1, 1);
    cond_in[0] = 1'b1;
    steps(4);
    chk("mid_pre_cnt", count_o[7:0], 8'd7);
    chk("mid_pre_flag", flag_o[0], 1'b1);
    #3 rst_n = 1'b0;
    m_reset();
    #1;
    chk_zero("mid_rst");
    steps(2);
    rst_n = 1'b1;
    steps(5);
    cond_in = '0;
    steps(3);

    do_reset();
    mode = 8'h10;
    cond_in[2] = 1'b1;
    steps(3);
    chk("any_set", any_flag_o, 1'b1);
    chk("any_flag2", flag_o[2], 1'b1);
    cond_in = '0;
    steps(3);
    clear = 4'h4;
    step();
    chk("any_clr", any_flag_o, 1'b0);
    chk("any_clr_flag", flag_o[2], 1'b0);
    clear = '0;

    do_reset();
    repeat (3000) begin
      if ($urandom_range(3) == 0) cond_in = 4'($urandom);
      if ($urandom_range(63) == 0) mode = 8'($urandom);
      clear = ($urandom_range(15) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(299) == 0) begin
        #3 rst_n = 1'b0;
        m_reset();
        #1;
        chk("rnd_rst", {count_o, flag_o, any_flag_o}, 0);
        step();
        rst_n = 1'b1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
